fft_onboard_top: RTL and testbench

FFT_ONBOARD_TOP -- requirements
Module: fft_onboard_top

---
 rtl/fft_onboard_top.sv | 271 +++++++++++++++++++++++++++
 tb/tb_fft_onboard_top.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_onboard_top.sv
// On-board self-test for a serial 4-point DFT core: LFSR stimulus, core, independent checker.
// Optional build macro FFT_ERR_INJECT_EN corrupts X2.re bit 0 of frame 5 to prove the checker.
module fft_onboard_top #(
  parameter int          NUM_FRAMES = 256,
  parameter int          DATA_W     = 16,
  parameter logic [31:0] LFSR_SEED  = 32'hACE11234
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_start_test,
  output logic o_err,
  output logic o_chk_finished
);

  localparam int            OW         = DATA_W + 2;
  localparam int            NS         = 4 * NUM_FRAMES;
  localparam int            CW         = $clog2(NS) + 1;
  localparam logic [CW-1:0] LAST_SMP   = CW'(NS - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(4);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t                     r_state, w_state_nxt;
  logic                       r_start_q, r_start_prev, r_armed;
  logic                       w_start_edge, w_start_run, w_smp_vld;
  logic [CW-1:0]              r_cnt;
  logic [31:0]                r_lfsr;
  logic signed [DATA_W-1:0]   w_smp_re, w_smp_im;

  // Core state
  logic [1:0]                 r_phase;
  logic signed [DATA_W-1:0]   r_cx_re [3];
  logic signed [DATA_W-1:0]   r_cx_im [3];
  logic signed [OW-1:0]       w_xr [4];
  logic signed [OW-1:0]       w_xi [4];
  logic signed [OW-1:0]       w_bin_re [4];
  logic signed [OW-1:0]       w_bin_im [4];
  logic signed [OW-1:0]       w_x2_re_out;
  logic signed [OW-1:0]       r_bin_re [4];
  logic signed [OW-1:0]       r_bin_im [4];
  logic                       r_emit_start;
  logic [1:0]                 r_oidx;
  logic signed [OW-1:0]       r_out_re, r_out_im;
  logic                       r_out_vld;

  // Checker state
  logic [1:0]                 r_kphase;
  logic signed [DATA_W-1:0]   r_kx_re [3];
  logic signed [DATA_W-1:0]   r_kx_im [3];
  logic signed [OW-1:0]       w_s02_re, w_s02_im, w_d02_re, w_d02_im;
  logic signed [OW-1:0]       w_s13_re, w_s13_im, w_d13_re, w_d13_im;
  logic signed [OW-1:0]       w_exp_re [4];
  logic signed [OW-1:0]       w_exp_im [4];
  logic signed [OW-1:0]       r_kbin_re [4];
  logic signed [OW-1:0]       r_kbin_im [4];
  logic                       r_kemit_start;
  logic [1:0]                 r_kidx;
  logic signed [OW-1:0]       r_exp_re, r_exp_im;
  logic                       r_exp_vld;
  logic                       w_mismatch;

  // Start qualifier: r_armed requires a low to be seen, so a level held through reset cannot start a run.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_start_q    <= 1'b0;
      r_start_prev <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_start_q    <= i_start_test;
      r_start_prev <= r_start_q;
      r_armed      <= r_armed | ~i_start_test;
    end
  end

  assign w_start_edge = r_start_q & ~r_start_prev & r_armed;
  assign w_start_run  = w_start_edge & ((r_state == S_IDLE) || (r_state == S_FIN));
  assign w_smp_vld    = (r_state == S_RUN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_FIN: if (w_start_run)          w_state_nxt = S_RUN;
      S_RUN:         if (r_cnt == LAST_SMP)    w_state_nxt = S_DRAIN;
      S_DRAIN:       if (r_cnt == DRAIN_LAST)  w_state_nxt = S_FIN;
      default:                                 w_state_nxt = S_IDLE;
    endcase
  end

  // Sample counter in RUN, then 5 drain edges covering the last frame's output and compare.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt          <= '0;
      r_lfsr         <= LFSR_SEED;
      o_chk_finished <= 1'b0;
    end else if (w_start_run) begin
      r_cnt          <= '0;
      r_lfsr         <= LFSR_SEED;
      o_chk_finished <= 1'b0;
    end else begin
      if (r_state == S_RUN) begin
        r_cnt  <= (r_cnt == LAST_SMP) ? '0 : r_cnt + CW'(1);
        r_lfsr <= {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
      end else if (r_state == S_DRAIN) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == DRAIN_LAST) o_chk_finished <= 1'b1;
      end
    end
  end

  assign w_smp_re = DATA_W'($signed(r_lfsr[31:16]));
  assign w_smp_im = DATA_W'($signed(r_lfsr[15:0]));

  // ---------------- DFT core: direct-form sums ----------------
  assign w_xr[0] = OW'(r_cx_re[0]);
  assign w_xr[1] = OW'(r_cx_re[1]);
  assign w_xr[2] = OW'(r_cx_re[2]);
  assign w_xr[3] = OW'(w_smp_re);
  assign w_xi[0] = OW'(r_cx_im[0]);
  assign w_xi[1] = OW'(r_cx_im[1]);
  assign w_xi[2] = OW'(r_cx_im[2]);
  assign w_xi[3] = OW'(w_smp_im);

  assign w_bin_re[0] = w_xr[0] + w_xr[1] + w_xr[2] + w_xr[3];
  assign w_bin_im[0] = w_xi[0] + w_xi[1] + w_xi[2] + w_xi[3];
  assign w_bin_re[1] = w_xr[0] + w_xi[1] - w_xr[2] - w_xi[3];
  assign w_bin_im[1] = w_xi[0] - w_xr[1] - w_xi[2] + w_xr[3];
  assign w_bin_re[2] = w_xr[0] - w_xr[1] + w_xr[2] - w_xr[3];
  assign w_bin_im[2] = w_xi[0] - w_xi[1] + w_xi[2] - w_xi[3];
  assign w_bin_re[3] = w_xr[0] - w_xi[1] - w_xr[2] + w_xi[3];
  assign w_bin_im[3] = w_xi[0] + w_xr[1] - w_xi[2] - w_xr[3];

`ifdef FFT_ERR_INJECT_EN
  logic [2:0] r_frame;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                          r_frame <= '0;
    else if (w_start_run)                               r_frame <= '0;
    else if (w_smp_vld && r_phase == 2'd3 && r_frame != 3'd7) r_frame <= r_frame + 3'd1;
  end

  assign w_x2_re_out = w_bin_re[2] ^ {{(OW-1){1'b0}}, (r_frame == 3'd5)};
`else
  assign w_x2_re_out = w_bin_re[2];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: these small arrays are plain flops, so they are reset with everything else.
      for (int k = 0; k < 3; k++) begin
        r_cx_re[k] <= '0;
        r_cx_im[k] <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        r_bin_re[k] <= '0;
        r_bin_im[k] <= '0;
      end
      r_phase      <= '0;
      r_emit_start <= 1'b0;
      r_oidx       <= '0;
      r_out_re     <= '0;
      r_out_im     <= '0;
      r_out_vld    <= 1'b0;
    end else begin
      r_emit_start <= 1'b0;
      if (w_start_run) begin
        r_phase <= '0;
      end else if (w_smp_vld) begin
        r_phase <= r_phase + 2'd1;
        case (r_phase)
          2'd0: begin r_cx_re[0] <= w_smp_re; r_cx_im[0] <= w_smp_im; end
          2'd1: begin r_cx_re[1] <= w_smp_re; r_cx_im[1] <= w_smp_im; end
          2'd2: begin r_cx_re[2] <= w_smp_re; r_cx_im[2] <= w_smp_im; end
          default: begin
            r_bin_re[0] <= w_bin_re[0];  r_bin_im[0] <= w_bin_im[0];
            r_bin_re[1] <= w_bin_re[1];  r_bin_im[1] <= w_bin_im[1];
            r_bin_re[2] <= w_x2_re_out;  r_bin_im[2] <= w_bin_im[2];
            r_bin_re[3] <= w_bin_re[3];  r_bin_im[3] <= w_bin_im[3];
            r_emit_start <= 1'b1;
          end
        endcase
      end
      // Serializer: X3 of one frame and X0 of the next land on adjacent cycles.
      if (r_emit_start || r_oidx != 2'd0) begin
        r_out_re  <= r_bin_re[r_oidx];
        r_out_im  <= r_bin_im[r_oidx];
        r_out_vld <= 1'b1;
        r_oidx    <= r_oidx + 2'd1;
      end else begin
        r_out_vld <= 1'b0;
      end
    end
  end

  // ---------------- Checker: radix-2 butterfly form ----------------
  assign w_s02_re = OW'(r_kx_re[0]) + OW'(r_kx_re[2]);
  assign w_s02_im = OW'(r_kx_im[0]) + OW'(r_kx_im[2]);
  assign w_d02_re = OW'(r_kx_re[0]) - OW'(r_kx_re[2]);
  assign w_d02_im = OW'(r_kx_im[0]) - OW'(r_kx_im[2]);
  assign w_s13_re = OW'(r_kx_re[1]) + OW'(w_smp_re);
  assign w_s13_im = OW'(r_kx_im[1]) + OW'(w_smp_im);
  assign w_d13_re = OW'(r_kx_re[1]) - OW'(w_smp_re);
  assign w_d13_im = OW'(r_kx_im[1]) - OW'(w_smp_im);

  assign w_exp_re[0] = w_s02_re + w_s13_re;
  assign w_exp_im[0] = w_s02_im + w_s13_im;
  assign w_exp_re[1] = w_d02_re + w_d13_im;
  assign w_exp_im[1] = w_d02_im - w_d13_re;
  assign w_exp_re[2] = w_s02_re - w_s13_re;
  assign w_exp_im[2] = w_s02_im - w_s13_im;
  assign w_exp_re[3] = w_d02_re - w_d13_im;
  assign w_exp_im[3] = w_d02_im + w_d13_re;

  assign w_mismatch = r_exp_vld && (!r_out_vld || r_out_re != r_exp_re || r_out_im != r_exp_im);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 3; k++) begin
        r_kx_re[k] <= '0;
        r_kx_im[k] <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        r_kbin_re[k] <= '0;
        r_kbin_im[k] <= '0;
      end
      r_kphase      <= '0;
      r_kemit_start <= 1'b0;
      r_kidx        <= '0;
      r_exp_re      <= '0;
      r_exp_im      <= '0;
      r_exp_vld     <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      r_kemit_start <= 1'b0;
      if (w_start_run) begin
        r_kphase <= '0;
      end else if (w_smp_vld) begin
        r_kphase <= r_kphase + 2'd1;
        case (r_kphase)
          2'd0: begin r_kx_re[0] <= w_smp_re; r_kx_im[0] <= w_smp_im; end
          2'd1: begin r_kx_re[1] <= w_smp_re; r_kx_im[1] <= w_smp_im; end
          2'd2: begin r_kx_re[2] <= w_smp_re; r_kx_im[2] <= w_smp_im; end
          default: begin
            for (int k = 0; k < 4; k++) begin
              r_kbin_re[k] <= w_exp_re[k];
              r_kbin_im[k] <= w_exp_im[k];
            end
            r_kemit_start <= 1'b1;
          end
        endcase
      end
      if (r_kemit_start || r_kidx != 2'd0) begin
        r_exp_re  <= r_kbin_re[r_kidx];
        r_exp_im  <= r_kbin_im[r_kidx];
        r_exp_vld <= 1'b1;
        r_kidx    <= r_kidx + 2'd1;
      end else begin
        r_exp_vld <= 1'b0;
      end
      if (w_start_run)     o_err <= 1'b0;
      else if (w_mismatch) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_onboard_top.sv
// Directed bench for fft_onboard_top: bin scoreboard on the core output, finish/err scoreboard.
`timescale 1ns/1ps
module tb_fft_onboard_top;

  localparam int          NF   = 256;
  localparam int          DW   = 16;
  localparam logic [31:0] SEED = 32'hACE11234;
`ifdef FFT_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  typedef struct {
    logic signed [DW+1:0] re;
    logic signed [DW+1:0] im;
  } bin_t;
  typedef struct {
    int   lat;
    logic err;
  } fin_t;

  logic clk = 1'b0;
  logic rstn, rstn1, start, start1;
  logic err, fin, err1, fin1;

  int   checks = 0, failures = 0;
  int   cyc = 0, start_cyc = 0, mon_cnt = 0;
  bit   fin_seen = 1'b0, fin_prev = 1'b0;
  bin_t sb_q[$];
  fin_t fin_q[$];
  bin_t mon_b;
  fin_t mon_f;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_onboard_top #(.NUM_FRAMES(NF), .DATA_W(DW), .LFSR_SEED(SEED)) u_dut (
    .clk(clk), .rstn(rstn), .i_start_test(start), .o_err(err), .o_chk_finished(fin)
  );
  fft_onboard_top #(.NUM_FRAMES(1), .DATA_W(DW), .LFSR_SEED(SEED)) u_dut1 (
    .clk(clk), .rstn(rstn1), .i_start_test(start1), .o_err(err1), .o_chk_finished(fin1)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Expected bins of a whole run, in output order.
  task automatic push_bins();
    logic [31:0] l;
    int   xr[4], xi[4];
    bin_t b[4];
    l = SEED;
    for (int f = 0; f < NF; f++) begin
      for (int s = 0; s < 4; s++) begin
        xr[s] = int'($signed(l[31:16]));
        xi[s] = int'($signed(l[15:0]));
        l = lfsr_next(l);
      end
      b[0].re = 18'(xr[0] + xr[1] + xr[2] + xr[3]);
      b[0].im = 18'(xi[0] + xi[1] + xi[2] + xi[3]);
      b[1].re = 18'(xr[0] + xi[1] - xr[2] - xi[3]);
      b[1].im = 18'(xi[0] - xr[1] - xi[2] + xr[3]);
      b[2].re = 18'(xr[0] - xr[1] + xr[2] - xr[3]);
      b[2].im = 18'(xi[0] - xi[1] + xi[2] - xi[3]);
      b[3].re = 18'(xr[0] - xi[1] - xr[2] + xi[3]);
      b[3].im = 18'(xi[0] + xr[1] - xi[2] - xr[3]);
      if (INJ && f == 5) b[2].re[0] = ~b[2].re[0];
      for (int k = 0; k < 4; k++) sb_q.push_back(b[k]);
    end
  endtask

  // Call at a negedge with start low; the next posedge is the start-sampling edge.
  task automatic do_start();
    fin_t e;
    e.lat = 4 * NF + 6;
    e.err = INJ;
    fin_q.push_back(e);
    push_bins();
    fin_seen  = 1'b0;
    start     = 1'b1;
    start_cyc = cyc + 1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_fin(input int budget);
    for (int k = 0; k < budget && !fin_seen; k++) @(negedge clk);
    check("fin_seen", fin_seen, 1);
  endtask

  always @(negedge clk) begin
    if (u_dut.r_out_vld === 1'b1) begin
      mon_cnt++;
      if (sb_q.size() == 0) begin
        check("bin_unexpected", 1, 0);
      end else begin
        mon_b = sb_q.pop_front();
        check("bin_re", u_dut.r_out_re, mon_b.re);
        check("bin_im", u_dut.r_out_im, mon_b.im);
      end
    end
  end

  always @(negedge clk) begin
    if (fin === 1'b1 && !fin_prev) begin
      fin_seen = 1'b1;
      if (fin_q.size() == 0) begin
        check("fin_unexpected", 1, 0);
      end else begin
        mon_f = fin_q.pop_front();
        check("fin_latency", cyc - start_cyc, mon_f.lat);
        check("fin_err", err, mon_f.err);
      end
    end
    fin_prev = (fin === 1'b1);
  end

  initial begin
    int s0, s1, mc;
    rstn = 1'b0; rstn1 = 1'b0; start = 1'b0; start1 = 1'b0;
    #50;
    check("rst_err", err, 0);
    check("rst_fin", fin, 0);
    check("rst_err1", err1, 0);
    check("rst_fin1", fin1, 0);
    #50;
    rstn = 1'b1; rstn1 = 1'b1;
    #100;

    // Run 1: normal run with a second start edge at cycle 100 that must be ignored.
    do_start();
    s0 = start_cyc;
    wait_until(s0 + 28);
    check("err_before_f5x2", err, 0);
    wait_until(s0 + 29);
    check("err_after_f5x2", err, INJ);
    wait_until(s0 + 50);
    start = 1'b0;
    wait_until(s0 + 99);
    start = 1'b1;
    wait_until(s0 + 120);
    check("busy_fin_low", fin, 0);
    wait_fin(1100);
    repeat (20) @(negedge clk);
    check("hold_fin", fin, 1);
    check("hold_err", err, INJ);
    check("sb_drained", sb_q.size(), 0);

    // Run 2: restart clears outputs and reproduces the same sequence.
    start = 1'b0;
    repeat (2) @(negedge clk);
    do_start();
    wait_until(start_cyc + 1);
    check("restart_err", err, 0);
    check("restart_fin", fin, 0);
    wait_fin(1100);

    // Asynchronous reset after finish, start held high through release.
    #2 rstn = 1'b0;
    #1;
    check("async_rst_fin", fin, 0);
    check("async_rst_err", err, 0);
    sb_q.delete(); fin_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    mc = mon_cnt;
    repeat (40) @(negedge clk);
    check("held_start_no_run", mon_cnt, mc);
    check("held_start_fin", fin, 0);

    // Run 3: aborted by reset at cycle 500.
    start = 1'b0;
    repeat (2) @(negedge clk);
    do_start();
    wait_until(start_cyc + 500);
    check("midrun_err", err, INJ);
    #2 rstn = 1'b0;
    #1;
    check("midrun_rst_err", err, 0);
    check("midrun_rst_fin", fin, 0);
    sb_q.delete(); fin_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    mc = mon_cnt;
    repeat (40) @(negedge clk);
    check("midrun_no_restart", mon_cnt, mc);
    check("midrun_fin_low", fin, 0);

    // Run 4: fresh toggle after reset gives a complete run.
    start = 1'b0;
    repeat (2) @(negedge clk);
    do_start();
    wait_fin(1100);
    check("run4_sb_drained", sb_q.size(), 0);

    // Single-frame instance.
    @(negedge clk);
    start1 = 1'b1;
    s1 = cyc + 1;
    for (int k = 0; k < 40 && fin1 !== 1'b1; k++) @(negedge clk);
    check("nf1_latency", cyc - s1, 10);
    check("nf1_err", err1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
